cache_line_xfer: RTL and testbench

- Downstream memory-side engine for the cache controller FSM.
- When the controller asserts EVICT/ALLOC, this block transfers whole lines over a word-wide memory bus.
  - Writeback: streams the dirty victim line out of the cache data array.
  - Refill: streams the new line into the cache data array.
- Reports completion with a single `done` pulse; the controller then returns to IDLE.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/cache_line_xfer_if.sv | 40 ++++
 rtl/cache_line_xfer.sv | 155 +++++++++++++++
 tb/tb_cache_line_xfer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache line transfer engine.
// Contents:
//   AddrWDef/DataWDef/WordsDef - default bus and line geometry
//   xfer_st_t                  - transfer engine state encoding
//   line_base()                - clears the in-line offset bits of an address
package cache_pkg;

  localparam int unsigned AddrWDef = 32;
  localparam int unsigned DataWDef = 32;
  localparam int unsigned WordsDef = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWb,
    StFill,
    StDone
  } xfer_st_t;

  // Zero the low `lsb` bits so the result points at the first byte of the line.
  // Works on a 64-bit container so callers of any address width can use it.
  function automatic logic [63:0] line_base(input logic [63:0] addr, input int unsigned lsb);
    logic [63:0] mask;
    mask = ~64'd0 << lsb;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_line_xfer_if.sv
// Word-wide memory bus between the line transfer engine and the memory side.
// Signals:
//   mem_req   - beat request, held until mem_ack
//   mem_we    - 1 = write beat, 0 = read beat
//   mem_addr  - word-aligned byte address of the current beat
//   mem_wdata - write beat data
//   mem_rdata - read beat data, valid with mem_ack
//   mem_ack   - beat accepted/completed this cycle
// Modports: master (transfer engine), slave (memory).
interface cache_line_xfer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/cache_line_xfer.sv
// Memory-side line transfer engine for the cache controller.
// On a request sampled in idle it writes back the victim line (evict_req),
// refills a new line (alloc_req), or does both in that order, one word per
// acknowledged beat, then pulses done for one cycle.
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   evict_req, alloc_req    - start writeback / refill (levels, sampled in idle)
//   victim_addr, line_addr  - any byte address inside the victim / new line
//   rd_idx, rd_data         - writeback read port of the cache data array
//   fill_we/idx/data        - refill write port of the cache data array
//   mem                     - memory bus (master side)
//   busy, done              - transfer in progress / one-cycle completion pulse
module cache_line_xfer
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDef,
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned WORDS  = WordsDef,
  localparam int unsigned BW    = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evict_req,
  input  logic              alloc_req,
  input  logic [ADDR_W-1:0] victim_addr,
  input  logic [ADDR_W-1:0] line_addr,
  output logic [BW-1:0]     rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              fill_we,
  output logic [BW-1:0]     fill_idx,
  output logic [DATA_W-1:0] fill_data,
  cache_line_xfer_if.master mem,
  output logic              busy,
  output logic              done
);

  localparam int unsigned ByteOff = $clog2(DATA_W / 8);
  localparam int unsigned LineLsb = BW + ByteOff;
  localparam logic [BW-1:0] LastBeat = BW'(WORDS - 1);
  // Line-base mask derived once at elaboration; applied to every accepted address.
  localparam logic [ADDR_W-1:0] LineMask = ADDR_W'(line_base(~64'd0, LineLsb));

  xfer_st_t          state_q, state_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [ADDR_W-1:0] vbase_q, vbase_d;
  logic [ADDR_W-1:0] lbase_q, lbase_d;
  logic              pend_fill_q, pend_fill_d;

  // Registered control outputs, decoded from the next state.
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic mem_req_q, mem_req_d;
  logic mem_we_q, mem_we_d;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    vbase_d     = vbase_q;
    lbase_d     = lbase_q;
    pend_fill_d = pend_fill_q;

    case (state_q)
      StIdle: begin
        if (evict_req || alloc_req) begin
          vbase_d     = victim_addr & LineMask;
          lbase_d     = line_addr & LineMask;
          beat_d      = '0;
          // Both requests at once: write back first, refill chained afterwards.
          pend_fill_d = evict_req && alloc_req;
          state_d     = evict_req ? StWb : StFill;
        end
      end
      StWb: begin
        if (mem.mem_ack) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LastBeat) begin
            beat_d      = '0;
            pend_fill_d = 1'b0;
            state_d     = pend_fill_q ? StFill : StDone;
          end
        end
      end
      StFill: begin
        if (mem.mem_ack) begin
          beat_d = beat_q + BW'(1);
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    mem_req_d = (state_d == StWb) || (state_d == StFill);
    mem_we_d  = (state_d == StWb);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      vbase_q     <= '0;
      lbase_q     <= '0;
      pend_fill_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      vbase_q     <= vbase_d;
      lbase_q     <= lbase_d;
      pend_fill_q <= pend_fill_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
    end
  end

  logic [ADDR_W-1:0] beat_off;
  logic              fill_beat;

  always_comb begin
    // Bases are line-aligned, so the word offset never carries into the tag.
    beat_off  = ADDR_W'(beat_q) << ByteOff;
    fill_beat = mem_req_q && !mem_we_q;

    mem.mem_req   = mem_req_q;
    mem.mem_we    = mem_we_q;
    mem.mem_addr  = '0;
    if (mem_req_q) begin
      mem.mem_addr = (mem_we_q ? vbase_q : lbase_q) | beat_off;
    end
    mem.mem_wdata = mem_we_q ? rd_data : '0;

    rd_idx    = beat_q;
    fill_we   = fill_beat && mem.mem_ack;
    fill_idx  = beat_q;
    fill_data = fill_we ? mem.mem_rdata : '0;

    busy = busy_q;
    done = done_q;
  end

endmodule

// File: tb/tb_cache_line_xfer.sv
module tb_cache_line_xfer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        evict_req = 1'b0;
  logic        alloc_req = 1'b0;
  logic [31:0] victim_addr = '0;
  logic [31:0] line_addr = '0;
  logic [1:0]  rd_idx;
  logic [31:0] rd_data;
  logic        fill_we;
  logic [1:0]  fill_idx;
  logic [31:0] fill_data;
  logic        busy;
  logic        done;

  logic [31:0] cache_arr [4];

  int n_checks = 0;
  int n_pass = 0;

  cache_line_xfer_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  cache_line_xfer #(
    .ADDR_W(32),
    .DATA_W(32),
    .WORDS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .evict_req  (evict_req),
    .alloc_req  (alloc_req),
    .victim_addr(victim_addr),
    .line_addr  (line_addr),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .fill_we    (fill_we),
    .fill_idx   (fill_idx),
    .fill_data  (fill_data),
    .mem        (mem_if),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Cache data array read port: combinational.
  assign rd_data = cache_arr[rd_idx];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- Reference model: a queue of pending beats ----------------
  typedef struct {
    bit          we;
    logic [31:0] addr;
    int          idx;
  } beat_t;

  beat_t mq[$];
  bit    done_due = 1'b0;

  task automatic push_line(input bit we, input logic [31:0] a);
    beat_t b;
    logic [31:0] base;
    base = a - (a % 32'd16);  // 4 words x 4 bytes per line
    for (int i = 0; i < 4; i++) begin
      b.we   = we;
      b.addr = base + 32'(4 * i);
      b.idx  = i;
      mq.push_back(b);
    end
  endtask

  initial begin : compare
    beat_t b;
    forever begin
      @(negedge clk);
      if (rst) begin
        mq.delete();
        done_due = 1'b0;
        check("m_rst_req", mem_if.mem_req, 0);
        check("m_rst_busy", busy, 0);
        check("m_rst_done", done, 0);
        check("m_rst_fwe", fill_we, 0);
      end else if (mq.size() > 0) begin
        b = mq[0];
        check("m_req", mem_if.mem_req, 1);
        check("m_we", mem_if.mem_we, b.we);
        check("m_addr", mem_if.mem_addr, b.addr);
        check("m_busy", busy, 1);
        check("m_done", done, 0);
        if (b.we) begin
          check("m_rd_idx", rd_idx, b.idx);
          check("m_wdata", mem_if.mem_wdata, cache_arr[b.idx]);
          check("m_wb_fwe", fill_we, 0);
        end else begin
          check("m_fwe", fill_we, mem_if.mem_ack);
          if (mem_if.mem_ack) begin
            check("m_fidx", fill_idx, b.idx);
            check("m_fdata", fill_data, mem_if.mem_rdata);
          end
        end
        if (mem_if.mem_ack) begin
          void'(mq.pop_front());
          if (mq.size() == 0) done_due = 1'b1;
        end
      end else if (done_due) begin
        check("m_done_pulse", done, 1);
        check("m_done_busy", busy, 1);
        check("m_done_req", mem_if.mem_req, 0);
        check("m_done_fwe", fill_we, 0);
        done_due = 1'b0;
      end else begin
        check("m_idle_busy", busy, 0);
        check("m_idle_done", done, 0);
        check("m_idle_req", mem_if.mem_req, 0);
        check("m_idle_fwe", fill_we, 0);
        if (evict_req) push_line(1'b1, victim_addr);
        if (alloc_req) push_line(1'b0, line_addr);
      end
    end
  end

  // ---------------- Stimulus and literal expectations ----------------
  task automatic run_cycle(input bit ev, input bit al, input bit ack, input logic [31:0] rdata);
    @(posedge clk);
    #1;
    evict_req        = ev;
    alloc_req        = al;
    mem_if.mem_ack   = ack;
    mem_if.mem_rdata = rdata;
    @(negedge clk);
  endtask

  initial begin : stim
    int done_cyc;
    int done_cnt;
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = '0;
    for (int i = 0; i < 4; i++) cache_arr[i] = 32'hD0 + 32'(i);

    #2;
    check("reset_req", mem_if.mem_req, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", mem_if.mem_addr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Refill only.
    line_addr = 32'h0000_1234;
    run_cycle(0, 1, 0, 0);
    check("t1_idle_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(0, 0, 1, 32'hA0 + 32'(k));
      check("t1_addr", mem_if.mem_addr, 32'h1230 + 32'(4 * k));
      check("t1_we", mem_if.mem_we, 0);
      check("t1_fwe", fill_we, 1);
      check("t1_fidx", fill_idx, k);
      check("t1_fdata", fill_data, 32'hA0 + 32'(k));
    end
    run_cycle(0, 0, 0, 0);
    check("t1_done", done, 1);
    run_cycle(0, 0, 0, 0);
    check("t1_after", {busy, done}, 2'b00);

    // Writeback only.
    victim_addr = 32'h0000_0F08;
    run_cycle(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      run_cycle(0, 0, 1, $urandom);
      check("t2_addr", mem_if.mem_addr, 32'hF00 + 32'(4 * k));
      check("t2_we", mem_if.mem_we, 1);
      check("t2_wdata", mem_if.mem_wdata, 32'hD0 + 32'(k));
      check("t2_fwe", fill_we, 0);
    end
    run_cycle(0, 0, 0, 0);
    check("t2_done", done, 1);
    run_cycle(0, 0, 0, 0);
    check("t2_single_done", done, 0);

    // Writeback then refill.
    victim_addr = 32'h100;
    line_addr   = 32'h200;
    run_cycle(1, 1, 0, 0);
    for (int c = 1; c <= 9; c++) begin
      run_cycle(0, 0, c <= 8, $urandom);
      check("t3_busy", busy, 1);
      check("t3_done", done, c == 9);
      if (c <= 4) check("t3_waddr", mem_if.mem_addr, 32'h100 + 32'(4 * (c - 1)));
      else if (c <= 8) check("t3_raddr", mem_if.mem_addr, 32'h200 + 32'(4 * (c - 5)));
    end
    run_cycle(0, 0, 0, 0);

    // Stalled memory: ack every 3rd cycle; acks also land in idle afterwards.
    victim_addr = 32'h3004;
    done_cyc = -1;
    done_cnt = 0;
    run_cycle(1, 0, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      run_cycle(0, 0, (c % 3) == 0, $urandom);
      if (c <= 3) check("t4_hold_addr", mem_if.mem_addr, 32'h3000);
      if (c <= 3) check("t4_hold_wdata", mem_if.mem_wdata, 32'hD0);
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    check("t4_done_cycle", done_cyc, 13);
    check("t4_done_count", done_cnt, 1);

    // Reset during refill beat 2, then a fresh refill.
    line_addr = 32'h40;
    run_cycle(0, 1, 0, 0);
    run_cycle(0, 0, 1, 32'h11);
    run_cycle(0, 0, 1, 32'h22);
    run_cycle(0, 0, 1, 32'h33);
    check("t5_fidx", fill_idx, 2);
    check("t5_fwe", fill_we, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_async_req", mem_if.mem_req, 0);
    check("t5_async_busy", busy, 0);
    check("t5_async_fwe", fill_we, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    line_addr = 32'h5554;
    alloc_req = 1'b1;
    mem_if.mem_ack = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      run_cycle(0, 0, 1, $urandom);
      check("t5_addr", mem_if.mem_addr, 32'h5550 + 32'(4 * k));
      check("t5_idx", fill_idx, k);
    end
    run_cycle(0, 0, 0, 0);
    check("t5_done", done, 1);

    // Requests while busy and acks in idle are ignored.
    victim_addr = 32'h700;
    line_addr   = 32'h900;
    run_cycle(1, 0, 0, 0);
    for (int k = 0; k < 5; k++) run_cycle(0, k == 1 || k == 4, k < 4, $urandom);
    check("t6_done", done, 1);
    for (int k = 0; k < 3; k++) begin
      run_cycle(0, 0, 1, $urandom);
      check("t6_idle", {busy, done, mem_if.mem_req, fill_we}, 4'b0000);
    end

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) cache_arr[i] = $urandom;
      victim_addr      = $urandom;
      line_addr        = $urandom;
      evict_req        = ($urandom_range(0, 3) == 0);
      alloc_req        = ($urandom_range(0, 3) == 0);
      mem_if.mem_ack   = ($urandom_range(0, 2) != 0);
      mem_if.mem_rdata = $urandom;
      @(negedge clk);
    end

    run_cycle(0, 0, 1, 0);
    repeat (12) run_cycle(0, 0, 1, 0);
    check("end_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
